// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched word, muxes operands with write-back bypass, flags load-use.
// Optional: define ID_ILLEGAL_TRAP_EN to add the registered illegal_ex flag.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic [29:0] pc_id,
    output logic [4:0]  rs1_adr_id,
    output logic [4:0]  rs2_adr_id,
    input  logic [31:0] rs1_rdata_id,
    input  logic [31:0] rs2_rdata_id,
    input  logic        wbk_wen,
    input  logic [4:0]  wbk_adr,
    input  logic [31:0] wbk_data,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic        flush_ex,
    input  logic        post_flush,
    output logic        stall_ld,
    output logic        stall_ld_ex,
    output logic [29:0] pc_ex,
    output logic [10:0] cmd_ex,
    output logic [2:0]  funct3_ex,
    output logic        funct7b5_ex,
    output logic [4:0]  rd_adr_ex,
    output logic        rd_wen_ex,
    output logic [31:0] imm_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_ex
`endif
);

    localparam int unsigned CMD_W   = 11;
    localparam int unsigned C_LUI   = 0;
    localparam int unsigned C_AUIPC = 1;
    localparam int unsigned C_JAL   = 2;
    localparam int unsigned C_JALR  = 3;
    localparam int unsigned C_BR    = 4;
    localparam int unsigned C_LOAD  = 5;
    localparam int unsigned C_STORE = 6;
    localparam int unsigned C_OPIMM = 7;
    localparam int unsigned C_OP    = 8;
    localparam int unsigned C_MISC  = 9;
    localparam int unsigned C_SYS   = 10;

    localparam logic [CMD_W-1:0] WEN_MASK = 11'b101_1010_1111;
    localparam logic [CMD_W-1:0] RS1_MASK = 11'b111_1111_1000;
    localparam logic [CMD_W-1:0] RS2_MASK = 11'b001_0101_0000;

    typedef struct packed {
        logic [29:0]      pc;
        logic [CMD_W-1:0] cmd;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic [4:0]       rd_adr;
        logic             rd_wen;
        logic [31:0]      imm;
        logic [31:0]      rs1_data;
        logic [31:0]      rs2_data;
    } ex_t;

    logic [CMD_W-1:0] cmd_dec;
    logic [31:0]      imm_dec;
    logic             op_f7_ok;
    logic             take;
    ex_t              dec, ex_d, ex_q;

    assign rs1_adr_id = inst_id[19:15];
    assign rs2_adr_id = inst_id[24:20];

    // funct7 0100000 only exists for SUB and SRA
    assign op_f7_ok = (inst_id[31:25] == 7'b0000000) ||
                      ((inst_id[31:25] == 7'b0100000) &&
                       ((inst_id[14:12] == 3'b000) || (inst_id[14:12] == 3'b101)));

    always_comb begin
        cmd_dec = '0;
        if (inst_id[1:0] == 2'b11) begin
            case (inst_id[6:2])
                5'b01101: cmd_dec[C_LUI]   = 1'b1;
                5'b00101: cmd_dec[C_AUIPC] = 1'b1;
                5'b11011: cmd_dec[C_JAL]   = 1'b1;
                5'b11001: cmd_dec[C_JALR]  = 1'b1;
                5'b11000: cmd_dec[C_BR]    = 1'b1;
                5'b00000: cmd_dec[C_LOAD]  = 1'b1;
                5'b01000: cmd_dec[C_STORE] = 1'b1;
                5'b00100: cmd_dec[C_OPIMM] = 1'b1;
                5'b01100: cmd_dec[C_OP]    = op_f7_ok;
                5'b00011: cmd_dec[C_MISC]  = 1'b1;
                5'b11100: cmd_dec[C_SYS]   = 1'b1;
                default:  cmd_dec          = '0;
            endcase
        end
    end

    always_comb begin
        imm_dec = '0;
        if (cmd_dec[C_LUI] | cmd_dec[C_AUIPC])
            imm_dec = {inst_id[31:12], 12'd0};
        else if (cmd_dec[C_JAL])
            imm_dec = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
        else if (cmd_dec[C_JALR] | cmd_dec[C_LOAD] | cmd_dec[C_OPIMM] | cmd_dec[C_MISC] | cmd_dec[C_SYS])
            imm_dec = {{20{inst_id[31]}}, inst_id[31:20]};
        else if (cmd_dec[C_STORE])
            imm_dec = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
        else if (cmd_dec[C_BR])
            imm_dec = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    end

    function automatic logic [31:0] sel_opnd(input logic [4:0] adr, input logic [31:0] rf,
                                             input logic wen, input logic [4:0] wadr,
                                             input logic [31:0] wdata);
        if (adr == 5'd0)
            return 32'd0;
        else if (wen && (wadr == adr))
            return wdata;
        else
            return rf;
    endfunction

    always_comb begin
        dec          = '0;
        dec.pc       = pc_id;
        dec.cmd      = cmd_dec;
        dec.funct3   = inst_id[14:12];
        dec.funct7b5 = inst_id[30];
        dec.rd_adr   = inst_id[11:7];
        dec.rd_wen   = (|(cmd_dec & WEN_MASK)) && (inst_id[11:7] != 5'd0);
        dec.imm      = imm_dec;
        dec.rs1_data = sel_opnd(rs1_adr_id, rs1_rdata_id, wbk_wen, wbk_adr, wbk_data);
        dec.rs2_data = sel_opnd(rs2_adr_id, rs2_rdata_id, wbk_wen, wbk_adr, wbk_data);
    end

    // Load in EX whose rd feeds a source of the instruction now in ID
    assign stall_ld = ex_q.cmd[C_LOAD] && (ex_q.rd_adr != 5'd0) &&
                      (((|(cmd_dec & RS1_MASK)) && (rs1_adr_id == ex_q.rd_adr)) ||
                       ((|(cmd_dec & RS2_MASK)) && (rs2_adr_id == ex_q.rd_adr))) &&
                      !flush_ex && !post_flush;

    assign take = !(flush_ex || post_flush || stall_ld);
    assign ex_d = take ? dec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_ld_ex <= 1'b0;
        end else if (rst_pipe) begin
            ex_q        <= '0;
            stall_ld_ex <= 1'b0;
        end else if (!stall) begin
            ex_q        <= ex_d;
            stall_ld_ex <= stall_ld;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    // An instruction that decodes to no command class is illegal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_ex <= 1'b0;
        else if (rst_pipe)
            illegal_ex <= 1'b0;
        else if (!stall)
            illegal_ex <= take && (cmd_dec == '0);
    end
`endif

    assign pc_ex       = ex_q.pc;
    assign cmd_ex      = ex_q.cmd;
    assign funct3_ex   = ex_q.funct3;
    assign funct7b5_ex = ex_q.funct7b5;
    assign rd_adr_ex   = ex_q.rd_adr;
    assign rd_wen_ex   = ex_q.rd_wen;
    assign imm_ex      = ex_q.imm;
    assign rs1_data_ex = ex_q.rs1_data;
    assign rs2_data_ex = ex_q.rs2_data;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed scenarios plus random stimulus against an instruction-level model.
module tb_id_stage;

    logic        clk, rst_n;
    logic [31:0] inst_id;
    logic [29:0] pc_id;
    logic [4:0]  rs1_adr_id, rs2_adr_id;
    logic [31:0] rs1_rdata_id, rs2_rdata_id;
    logic        wbk_wen;
    logic [4:0]  wbk_adr;
    logic [31:0] wbk_data;
    logic        stall, rst_pipe, flush_ex, post_flush;
    logic        stall_ld, stall_ld_ex;
    logic [29:0] pc_ex;
    logic [10:0] cmd_ex;
    logic [2:0]  funct3_ex;
    logic        funct7b5_ex;
    logic [4:0]  rd_adr_ex;
    logic        rd_wen_ex;
    logic [31:0] imm_ex, rs1_data_ex, rs2_data_ex;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        illegal_ex;
`endif

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id),
        .rs1_adr_id(rs1_adr_id), .rs2_adr_id(rs2_adr_id),
        .rs1_rdata_id(rs1_rdata_id), .rs2_rdata_id(rs2_rdata_id),
        .wbk_wen(wbk_wen), .wbk_adr(wbk_adr), .wbk_data(wbk_data),
        .stall(stall), .rst_pipe(rst_pipe), .flush_ex(flush_ex), .post_flush(post_flush),
        .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex), .pc_ex(pc_ex), .cmd_ex(cmd_ex),
        .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex), .rd_adr_ex(rd_adr_ex),
        .rd_wen_ex(rd_wen_ex), .imm_ex(imm_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex)
`ifdef ID_ILLEGAL_TRAP_EN
        , .illegal_ex(illegal_ex)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] pc;
        logic [10:0] cmd;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] imm, d1, d2;
        logic        ill;
        logic        sl_ex;
    } st_t;

    typedef struct packed {
        st_t        s;
        logic [4:0] a1, a2;
        logic       sl;
    } exp_t;

    exp_t q[$];
    st_t  m;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Class index 0..10 in cmd_ex bit order, -1 for anything that must become a bubble
    function automatic int cls_of(input logic [31:0] i);
        logic [6:0] opc;
        logic [6:0] f7;
        opc = i[6:0];
        f7  = i[31:25];
        case (opc)
            7'h37: return 0;
            7'h17: return 1;
            7'h6F: return 2;
            7'h67: return 3;
            7'h63: return 4;
            7'h03: return 5;
            7'h23: return 6;
            7'h13: return 7;
            7'h33: begin
                if (f7 == 7'h00) return 8;
                if (f7 == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5)) return 8;
                return -1;
            end
            7'h0F: return 9;
            7'h73: return 10;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input int cls, input logic [31:0] i);
        case (cls)
            0, 1:          return {i[31:12], 12'd0};
            2:             return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3, 5, 7, 9, 10: return 32'($signed(i[31:20]));
            6:             return 32'($signed({i[31:25], i[11:7]}));
            4:             return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            default:       return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (wbk_wen && wbk_adr == a) return wbk_data;
        return rf;
    endfunction

    // Predict this cycle's outputs from the present inputs, then advance the model by one edge
    task automatic apply();
        int   cls;
        logic u1, u2, sl;
        exp_t e;
        st_t  nx;
        if (!rst_n) m = '0;
        cls = cls_of(inst_id);
        u1  = (cls >= 3);
        u2  = (cls == 4 || cls == 6 || cls == 8);
        sl  = rst_n && m.cmd[5] && (m.rd != 0) &&
              ((u1 && inst_id[19:15] == m.rd) || (u2 && inst_id[24:20] == m.rd)) &&
              !flush_ex && !post_flush;
        e.s  = m;
        e.a1 = inst_id[19:15];
        e.a2 = inst_id[24:20];
        e.sl = sl;
        q.push_back(e);
        n_push++;
        if (!rst_n || rst_pipe) nx = '0;
        else if (stall) nx = m;
        else begin
            nx = '0;
            nx.sl_ex = sl;
            if (!(flush_ex || post_flush || sl)) begin
                nx.pc   = pc_id;
                nx.f3   = inst_id[14:12];
                nx.f7b5 = inst_id[30];
                nx.rd   = inst_id[11:7];
                nx.d1   = opnd(inst_id[19:15], rs1_rdata_id);
                nx.d2   = opnd(inst_id[24:20], rs2_rdata_id);
                nx.ill  = (cls < 0);
                if (cls >= 0) begin
                    nx.cmd = 11'(1) << cls;
                    nx.wen = (inst_id[11:7] != 0) && !(cls == 4 || cls == 6 || cls == 9);
                    nx.imm = imm_of(cls, inst_id);
                end
            end
        end
        m = nx;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                chk("rs1_adr_id",  32'(rs1_adr_id),  32'(e.a1));
                chk("rs2_adr_id",  32'(rs2_adr_id),  32'(e.a2));
                chk("stall_ld",    32'(stall_ld),    32'(e.sl));
                chk("stall_ld_ex", 32'(stall_ld_ex), 32'(e.s.sl_ex));
                chk("pc_ex",       32'(pc_ex),       32'(e.s.pc));
                chk("cmd_ex",      32'(cmd_ex),      32'(e.s.cmd));
                chk("funct3_ex",   32'(funct3_ex),   32'(e.s.f3));
                chk("funct7b5_ex", 32'(funct7b5_ex), 32'(e.s.f7b5));
                chk("rd_adr_ex",   32'(rd_adr_ex),   32'(e.s.rd));
                chk("rd_wen_ex",   32'(rd_wen_ex),   32'(e.s.wen));
                chk("imm_ex",      imm_ex,           e.s.imm);
                chk("rs1_data_ex", rs1_data_ex,      e.s.d1);
                chk("rs2_data_ex", rs2_data_ex,      e.s.d2);
`ifdef ID_ILLEGAL_TRAP_EN
                chk("illegal_ex",  32'(illegal_ex),  32'(e.s.ill));
`endif
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; rst_pipe = 0; flush_ex = 0; post_flush = 0;
        wbk_wen = 0; wbk_adr = 0; wbk_data = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [6:0]  opcs [11];
        int          k;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        i = $urandom;
        k = $urandom_range(0, 13);
        if (k >= 12) return i;
        i[6:0]   = opcs[k > 10 ? 8 : k];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if (k == 8) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return i;
    endfunction

    initial begin : stim
        rst_n = 0; idle();
        inst_id = 0; pc_id = 0; rs1_rdata_id = 0; rs2_rdata_id = 0;
        m = '0;
        repeat (2) @(posedge clk);
        sync();
        chk("rst_cmd_ex", 32'(cmd_ex), 32'd0);
        chk("rst_stall_ld_ex", 32'(stall_ld_ex), 32'd0);
        chk("rst_stall_ld", 32'(stall_ld), 32'd0);

        rst_n = 1; inst_id = 32'h0000_0013; pc_id = 30'd1; apply();
        sync();
        chk("nop_cmd", 32'(cmd_ex), 32'h080);
        chk("nop_wen", 32'(rd_wen_ex), 32'd0);
        chk("nop_imm", imm_ex, 32'd0);

        inst_id = 32'hFFF0_8093; rs1_rdata_id = 32'd5; apply();
        sync();
        chk("addi_imm", imm_ex, 32'hFFFF_FFFF);
        chk("addi_rs1", rs1_data_ex, 32'd5);
        chk("addi_rd", 32'(rd_adr_ex), 32'd1);
        chk("addi_wen", 32'(rd_wen_ex), 32'd1);

        inst_id = 32'h0001_2283; apply();
        sync();
        inst_id = 32'h0012_8333; apply();
        #1 chk("ld_use_stall", 32'(stall_ld), 32'd1);
        sync();
        chk("ld_use_bubble", 32'(cmd_ex), 32'd0);
        chk("ld_use_sl_ex", 32'(stall_ld_ex), 32'd1);
        apply();
        #1 chk("ld_use_clear", 32'(stall_ld), 32'd0);
        sync();
        chk("ld_use_issue", 32'(cmd_ex), 32'h100);
        chk("ld_use_rd", 32'(rd_adr_ex), 32'd6);

        inst_id = 32'h0001_8213; rs1_rdata_id = 0;
        wbk_wen = 1; wbk_adr = 5'd3; wbk_data = 32'hDEAD_BEEF; apply();
        sync();
        chk("bypass_rs1", rs1_data_ex, 32'hDEAD_BEEF);
        idle();

        inst_id = 32'h0001_2283; apply();
        sync();
        inst_id = 32'h0012_8333; flush_ex = 1; apply();
        #1 chk("flush_no_stall", 32'(stall_ld), 32'd0);
        sync();
        chk("flush_bubble", 32'(cmd_ex), 32'd0);
        flush_ex = 0; post_flush = 1; apply();
        sync();
        chk("post_flush_bubble", 32'(cmd_ex), 32'd0);
        post_flush = 0; apply();
        sync();
        chk("after_flush_issue", 32'(cmd_ex), 32'h100);

        inst_id = 32'hFFF0_8093; rs1_rdata_id = 32'd5; apply();
        for (int c = 0; c < 3; c++) begin
            sync();
            stall = 1; inst_id = rand_inst(); rs1_rdata_id = $urandom; apply();
        end
        sync();
        chk("stall_cmd", 32'(cmd_ex), 32'h080);
        chk("stall_imm", imm_ex, 32'hFFFF_FFFF);
        chk("stall_rs1", rs1_data_ex, 32'd5);
        stall = 0; inst_id = 32'h0080_006F; apply();
        sync();
        chk("jal_imm", imm_ex, 32'd8);
        chk("jal_cmd", 32'(cmd_ex), 32'h004);

        for (int c = 0; c < 2000; c++) begin
            rst_n        = (c != 1000);
            inst_id      = rand_inst();
            pc_id        = 30'($urandom);
            rs1_rdata_id = $urandom;
            rs2_rdata_id = $urandom;
            wbk_wen      = $urandom_range(0, 1) == 1;
            wbk_adr      = 5'($urandom_range(0, 7));
            wbk_data     = $urandom;
            stall        = $urandom_range(0, 9) == 0;
            flush_ex     = $urandom_range(0, 11) == 0;
            post_flush   = $urandom_range(0, 11) == 0;
            rst_pipe     = $urandom_range(0, 39) == 0;
            apply();
            sync();
        end

        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        chk("scoreboard_pops", 32'(n_pop), 32'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
